bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 27 ++
 rtl/bcd_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 tb/tb_bin2bcd_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Minimum BCD digit count for an unsigned value of 'width' bits:
  // the number of decimal digits in 2^width - 1.
  function automatic int unsigned bcd_digits(input int unsigned width);
    logic [63:0] v;
    int unsigned n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] i_din,
  output logic [3:0] o_dout
);

  // Correct one BCD digit ahead of the left shift
  always_comb o_dout = (i_din >= 4'd5) ? i_din + 4'd3 : i_din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with valid/ready handshakes on both sides and optional signed input.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be in 2..32");
  end
  if (DIGITS < bcd_digits(WIDTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_dig;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_sign;
  logic                r_neg;
  logic [4*DIGITS-1:0] w_adj;
  logic [WIDTH-1:0]    w_mag;
  logic                w_neg;
  logic                w_in_ready;
  logic                w_accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_din  (r_dig[4*g +: 4]),
      .o_dout (w_adj[4*g +: 4])
    );
  end

  // Magnitude and sign of the offered word
  always_comb begin
    w_neg = (SIGNED != 1'b0) && binary[WIDTH-1];
    w_mag = w_neg ? -binary : binary;
  end

  // Next-state, handshake and status outputs
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == CW'(WIDTH)) w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = in_valid ? ST_SHIFT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    w_accept   = w_in_ready && in_valid;
    in_ready   = w_in_ready;
    out_valid  = (r_state == ST_DONE);
    busy       = (r_state == ST_SHIFT);
    bcd        = r_bcd;
    sign       = r_sign;
  end

  // State register and datapath. Counter values 0..WIDTH-1 perform the
  // shifts; the final count publishes digits and sign together, so the
  // outputs never show a half-converted word and stay put between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_dig   <= '0;
      r_bcd   <= '0;
      r_sign  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shift <= w_mag;
        r_dig   <= '0;
        r_cnt   <= '0;
        r_neg   <= w_neg;
      end else if (r_state == ST_SHIFT) begin
        if (r_cnt == CW'(WIDTH)) begin
          r_bcd  <= r_dig;
          r_sign <= r_neg;
        end else begin
          {r_dig, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt            <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three instances (8-bit unsigned, 8-bit signed,
// 16-bit unsigned) checked against an arithmetic decimal reference.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv  [3];
  logic        orr [3];
  logic        rdy [3];
  logic        ovl [3];
  logic        bsy [3];
  logic        sgn [3];
  logic [7:0]  bin_u8, bin_s8;
  logic [15:0] bin_u16;
  logic [11:0] bcd_u8, bcd_s8;
  logic [19:0] bcd_u16;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .binary(bin_u8), .out_valid(ovl[0]), .out_ready(orr[0]),
    .bcd(bcd_u8), .sign(sgn[0]), .busy(bsy[0]));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .binary(bin_s8), .out_valid(ovl[1]), .out_ready(orr[1]),
    .bcd(bcd_s8), .sign(sgn[1]), .busy(bsy[1]));

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
    .binary(bin_u16), .out_valid(ovl[2]), .out_ready(orr[2]),
    .bcd(bcd_u16), .sign(sgn[2]), .busy(bsy[2]));

  function automatic int wid(input int d);
    return (d == 2) ? 16 : 8;
  endfunction

  function automatic logic [19:0] get_bcd(input int d);
    case (d)
      0:       return {8'h00, bcd_u8};
      1:       return {8'h00, bcd_s8};
      default: return bcd_u16;
    endcase
  endfunction

  task automatic set_bin(input int d, input logic [15:0] v);
    case (d)
      0:       bin_u8  = v[7:0];
      1:       bin_s8  = v[7:0];
      default: bin_u16 = v;
    endcase
  endtask

  // Reference: decimal digits by repeated division, sign/magnitude by plain arithmetic
  function automatic logic [19:0] ref_bcd(input int unsigned mag);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  task automatic ref_model(input int d, input logic [15:0] v,
                           output logic [19:0] exp_bcd, output logic exp_sign);
    int unsigned val;
    val = (d == 2) ? int'(v) : int'(v[7:0]);
    exp_sign = 1'b0;
    if (d == 1 && val >= 128) begin
      exp_sign = 1'b1;
      val      = 256 - val;
    end
    exp_bcd = ref_bcd(val);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input int d, input logic [15:0] v);
    int k;
    k = 0;
    while (!rdy[d] && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_before_accept", 32'(rdy[d]), 32'd1);
    iv[d] = 1'b1;
    set_bin(d, v);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    set_bin(d, 16'($urandom));
  endtask

  task automatic expect_result(input int d, input logic [15:0] v, input string tag);
    int lat;
    logic [19:0] eb;
    logic es;
    ref_model(d, v, eb, es);
    lat = 0;
    while (!ovl[d] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check({tag, "_busy"}, 32'(bsy[d]), 32'd1);
    end
    check({tag, "_latency"}, 32'(lat), 32'(wid(d) + 1));
    check({tag, "_bcd"}, 32'(get_bcd(d)), 32'(eb));
    check({tag, "_sign"}, 32'(sgn[d]), 32'(es));
  endtask

  task automatic ack(input int d, input string tag);
    logic [19:0] held;
    held = get_bcd(d);
    orr[d] = 1'b1;
    @(posedge clk); #1;
    orr[d] = 1'b0;
    check({tag, "_ack_valid_low"}, 32'(ovl[d]), 32'd0);
    check({tag, "_ack_bcd_kept"}, 32'(get_bcd(d)), 32'(held));
  endtask

  task automatic convert(input int d, input logic [15:0] v, input string tag);
    start(d, v);
    expect_result(d, v, tag);
    ack(d, tag);
  endtask

  initial begin
    logic [19:0] held;
    for (int i = 0; i < 3; i++) begin
      iv[i]  = 1'b0;
      orr[i] = 1'b0;
    end
    bin_u8 = '0; bin_s8 = '0; bin_u16 = '0;

    // Reset state
    #20;
    for (int i = 0; i < 3; i++) begin
      check("reset_out_valid", 32'(ovl[i]), 32'd0);
      check("reset_busy", 32'(bsy[i]), 32'd0);
      check("reset_bcd", 32'(get_bcd(i)), 32'd0);
      check("reset_sign", 32'(sgn[i]), 32'd0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check("first_clk_in_ready", 32'(rdy[i]), 32'd1);

    // Unsigned 8-bit: directed corners, then every value
    convert(0, 16'd255, "u8_255");
    convert(0, 16'd0, "u8_0");
    convert(0, 16'd100, "u8_100");
    for (int v = 0; v < 256; v++) convert(0, 16'(v), "u8_sweep");

    // Signed 8-bit: directed corners, then every value
    convert(1, 16'h0080, "s8_80");
    convert(1, 16'h00FF, "s8_FF");
    convert(1, 16'h007F, "s8_7F");
    for (int v = 0; v < 256; v++) convert(1, 16'(v), "s8_sweep");

    // 16-bit: max value, stall with out_ready low, ignored in_valid
    start(2, 16'hFFFF);
    expect_result(2, 16'hFFFF, "u16_max");
    for (int i = 0; i < 10; i++) begin
      iv[2] = 1'b1;
      set_bin(2, 16'($urandom));
      @(posedge clk); #1;
      check("u16_stall_valid", 32'(ovl[2]), 32'd1);
      check("u16_stall_bcd", 32'(bcd_u16), 32'h65535);
      check("u16_stall_in_ready", 32'(rdy[2]), 32'd0);
    end
    iv[2] = 1'b0;
    ack(2, "u16_max");

    // 16-bit random words with random consumer delay
    for (int i = 0; i < 40; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      start(2, rv);
      expect_result(2, rv, "u16_rand");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check("u16_rand_hold_valid", 32'(ovl[2]), 32'd1);
      ack(2, "u16_rand");
    end

    // Back-to-back: transfer and accept in the same DONE cycle
    start(0, 16'd255);
    expect_result(0, 16'd255, "b2b_first");
    orr[0] = 1'b1;
    iv[0]  = 1'b1;
    set_bin(0, 16'd42);
    #1;
    check("b2b_in_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    orr[0] = 1'b0;
    iv[0]  = 1'b0;
    set_bin(0, 16'd99);
    expect_result(0, 16'd42, "b2b_42");
    check("b2b_42_value", 32'(bcd_u8), 32'h042);
    ack(0, "b2b_42");

    // Reset in the middle of a conversion
    start(0, 16'd200);
    repeat (3) @(posedge clk);
    #1;
    held = get_bcd(0);
    check("midshift_busy", 32'(bsy[0]), 32'd1);
    check("midshift_bcd_held", 32'(held), 32'h042);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(ovl[0]), 32'd0);
    check("rst_bcd", 32'(bcd_u8), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_in_ready", 32'(rdy[0]), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_in_ready", 32'(rdy[0]), 32'd1);
    check("rst_release_valid", 32'(ovl[0]), 32'd0);
    convert(0, 16'd37, "post_rst_37");
    convert(1, 16'h00C8, "post_rst_s8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
